// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with ready/valid handshake, LATENCY register
// stages under one global advance enable, and an opaque tag riding with each op.
// Build option: define ALU_PIPE_MUL_EN to build the multiplier. Without it,
// opcode 6 (MUL) decodes as illegal and no multiplier logic exists.
module alu_pipe #(
   parameter int W       = 16,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_res,
   output logic [2*W-1:0]   out_mul,
   output logic             out_carry,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int PW = 2 * W;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_ADDC = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_MUL  = 4'd6;
   localparam logic [3:0] OP_SEQ  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SLTS = 4'd9;

   // One global enable: the whole pipe moves, bubbles included, or nothing moves.
   logic adv;

   // Stage registers; index LATENCY-1 is the output stage.
   logic [LATENCY-1:0]            vld_q, vld_d;
   logic [LATENCY-1:0]            cy_q, cy_d;
   logic [LATENCY-1:0]            ill_q, ill_d;
   logic [LATENCY-1:0][W-1:0]     res_q, res_d;
   logic [LATENCY-1:0][PW-1:0]    mul_q, mul_d;
   logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;

   // Front-end (pre-stage-0) results.
   logic [W-1:0]  f_res;
   logic [PW-1:0] f_mul;
   logic          f_cy;
   logic          f_ill;
   logic [W:0]    sum_c;
   logic [W:0]    dif_c;
   logic          cin_add;

   assign adv      = !vld_q[LATENCY-1] || out_ready;
   assign in_ready = adv;

   assign cin_add = (in_op == OP_ADDC) && in_cin;
   assign sum_c   = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, cin_add};
   // Bit W of the extended difference is the borrow; carry out is its inverse.
   assign dif_c   = {1'b0, in_a} - {1'b0, in_b};

`ifdef ALU_PIPE_MUL_EN
   // Product split into two half-width partial products on b.
   localparam int H = W / 2;
   logic [PW-1:0] pp_lo_c, pp_hi_c;
   logic [PW-1:0] prod_s0;   // full product available at the front
   logic [PW-1:0] prod_s1;   // full product merged on the way into stage 1
   logic          mul_s1;    // stage 0 holds a MUL awaiting its merge

   assign pp_lo_c = PW'(in_a) * PW'(in_b[H-1:0]);
   assign pp_hi_c = PW'(in_a) * PW'(in_b[W-1:H]);

   if (LATENCY == 1) begin : g_mul_comb
      assign prod_s0 = pp_lo_c + (pp_hi_c << H);
      assign prod_s1 = '0;
      assign mul_s1  = 1'b0;
   end else begin : g_mul_split
      logic [PW-1:0] lo_q, hi_q;
      logic          m_q;
      // Stage 0 keeps the partial products; the final add happens into stage 1.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            lo_q <= '0;
            hi_q <= '0;
            m_q  <= 1'b0;
         end else if (adv) begin
            lo_q <= pp_lo_c;
            hi_q <= pp_hi_c;
            m_q  <= in_valid && (in_op == OP_MUL);
         end
      end
      assign prod_s0 = '0;
      assign prod_s1 = lo_q + (hi_q << H);
      assign mul_s1  = m_q;
   end
`endif

   // Opcode decode and arithmetic for the op being offered.
   always_comb begin
      f_res = '0;
      f_mul = '0;
      f_cy  = 1'b0;
      f_ill = 1'b0;
      case (in_op)
         OP_AND:  f_res = in_a & in_b;
         OP_OR:   f_res = in_a | in_b;
         OP_XOR:  f_res = in_a ^ in_b;
         OP_ADD, OP_ADDC: begin
            f_res = sum_c[W-1:0];
            f_cy  = sum_c[W];
         end
         OP_SUB: begin
            f_res = dif_c[W-1:0];
            f_cy  = ~dif_c[W];
         end
`ifdef ALU_PIPE_MUL_EN
         OP_MUL: begin
            f_res = prod_s0[W-1:0];
            f_mul = prod_s0;
         end
`endif
         OP_SEQ:  f_res = {{(W-1){1'b0}}, (in_a == in_b)};
         OP_SLTU: f_res = {{(W-1){1'b0}}, (in_a < in_b)};
         OP_SLTS: f_res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         default: f_ill = 1'b1;
      endcase
   end

   // Next-state for every stage: stage 0 takes the front end, others shift.
   always_comb begin
      vld_d[0] = in_valid;
      res_d[0] = in_valid ? f_res : '0;
      mul_d[0] = in_valid ? f_mul : '0;
      cy_d[0]  = in_valid && f_cy;
      ill_d[0] = in_valid && f_ill;
      tag_d[0] = in_valid ? in_tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         res_d[i] = res_q[i-1];
         mul_d[i] = mul_q[i-1];
         cy_d[i]  = cy_q[i-1];
         ill_d[i] = ill_q[i-1];
         tag_d[i] = tag_q[i-1];
`ifdef ALU_PIPE_MUL_EN
         if (i == 1 && mul_s1) begin
            res_d[i] = prod_s1[W-1:0];
            mul_d[i] = prod_s1;
         end
`endif
      end
   end

   // Stage registers: cleared on reset, advance together only when adv is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         res_q <= '0;
         mul_q <= '0;
         cy_q  <= '0;
         ill_q <= '0;
         tag_q <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
         res_q <= res_d;
         mul_q <= mul_d;
         cy_q  <= cy_d;
         ill_q <= ill_d;
         tag_q <= tag_d;
      end
   end

   assign out_valid   = vld_q[LATENCY-1];
   assign out_res     = res_q[LATENCY-1];
   assign out_mul     = mul_q[LATENCY-1];
   assign out_carry   = cy_q[LATENCY-1];
   assign out_illegal = ill_q[LATENCY-1];
   assign out_tag     = tag_q[LATENCY-1];

endmodule
